// File: rtl/pong_row_renderer.sv
// Scan-line renderer for the pong LED matrix: scans rows, snapshots the game state once per
// frame and drives the lit-column pattern of the active row with blink/flash/blank modes.
module pong_row_renderer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned POS_BITS     = 3,
  parameter int unsigned ROW_BITS     = 3,
  parameter int unsigned PAD_LEN      = 2,
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [POS_BITS-1:0] player_top,
  input  logic [POS_BITS-1:0] player_down,
  input  logic [POS_BITS-1:0] x_pos,
  input  logic [ROW_BITS-1:0] y_pos,
  input  logic [1:0]          mode,
  output logic [ROW_BITS-1:0] row_out,
  output logic [ROWS-1:0]     row_en,
  output logic [WIDTH-1:0]    col_out,
  output logic                frame_start
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned FrmW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [ScanW-1:0]    ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [ROW_BITS-1:0] RowLast  = ROW_BITS'(ROWS - 1);
  localparam logic [FrmW-1:0]     FrmLast  = FrmW'(BLINK_FRAMES - 1);

  logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [FrmW-1:0]     frm_cnt_q, frm_cnt_d;
  logic                blink_q, blink_d;
  logic                valid_q, valid_d;
  logic [POS_BITS-1:0] top_q, top_d, down_q, down_d, x_q, x_d;
  logic [ROW_BITS-1:0] y_q, y_d;
  logic [1:0]          mode_q, mode_d;

  logic [ROW_BITS-1:0] row_out_q, row_out_d;
  logic [ROWS-1:0]     row_en_q, row_en_d;
  logic [WIDTH-1:0]    col_out_q, col_out_d;
  logic                frame_start_q, frame_start_d;

  logic row_end, frame_end;

  function automatic logic [WIDTH-1:0] paddle(input logic [POS_BITS-1:0] p);
    logic [WIDTH-1:0] res;
    res = '0;
    // A paddle that would run off the right edge is dropped, not clipped.
    if (int'(p) <= int'(WIDTH) - int'(PAD_LEN)) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        res[i] = (i >= int'(p)) && (i < int'(p) + int'(PAD_LEN));
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      row_q         <= '0;
      frm_cnt_q     <= '0;
      blink_q       <= 1'b0;
      valid_q       <= 1'b0;
      top_q         <= '0;
      down_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      mode_q        <= '0;
      row_out_q     <= '0;
      row_en_q      <= '0;
      col_out_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      row_q         <= row_d;
      frm_cnt_q     <= frm_cnt_d;
      blink_q       <= blink_d;
      valid_q       <= valid_d;
      top_q         <= top_d;
      down_q        <= down_d;
      x_q           <= x_d;
      y_q           <= y_d;
      mode_q        <= mode_d;
      row_out_q     <= row_out_d;
      row_en_q      <= row_en_d;
      col_out_q     <= col_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Scan timing, frame counter and the once-per-frame snapshot.
  always_comb begin
    row_end    = (scan_cnt_q == ScanLast);
    frame_end  = row_end && (row_q == RowLast);
    scan_cnt_d = row_end ? '0 : scan_cnt_q + 1'b1;
    row_d      = row_q;
    frm_cnt_d  = frm_cnt_q;
    blink_d    = blink_q;
    valid_d    = valid_q;
    top_d      = top_q;
    down_d     = down_q;
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    if (row_end) begin
      row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
    end
    if (frame_end) begin
      valid_d = 1'b1;
      top_d   = player_top;
      down_d  = player_down;
      x_d     = x_pos;
      y_d     = y_pos;
      mode_d  = mode;
      if (frm_cnt_q == FrmLast) begin
        frm_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        frm_cnt_d = frm_cnt_q + 1'b1;
      end
    end
  end

  // Registered row outputs, all computed from the same current-row state.
  always_comb begin
    logic [WIDTH-1:0] pattern;
    logic             ball_ok;
    pattern = '0;
    ball_ok = (int'(x_q) < int'(WIDTH)) && (int'(y_q) < int'(ROWS)) && (y_q == row_q) &&
              !((mode_q == 2'd1) && blink_q);
    if (row_q == '0) pattern = pattern | paddle(top_q);
    if (row_q == RowLast) pattern = pattern | paddle(down_q);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (ball_ok && (int'(x_q) == i)) pattern[i] = 1'b1;
    end

    case (mode_q)
      2'd2:    col_out_d = {WIDTH{blink_q}};
      2'd3:    col_out_d = '0;
      default: col_out_d = pattern;
    endcase
    if (!valid_q) col_out_d = '0;

    for (int i = 0; i < int'(ROWS); i++) begin
      row_en_d[i] = (int'(row_q) == i);
    end
    row_out_d     = row_q;
    frame_start_d = valid_q && (row_q == '0) && (scan_cnt_q == '0);
  end

  assign row_out     = row_out_q;
  assign row_en      = row_en_q;
  assign col_out     = col_out_q;
  assign frame_start = frame_start_q;

endmodule
